// File: rtl/ram_arbiter.sv
// Two-master arbiter/sequencer for the single-port data RAM: one transaction every 3 cycles, request-to-response latency 2 cycles.
// Backpressure: ready only in IDLE; responses are single-cycle pulses and cannot be stalled. RAM_ARB_FIXED_PRIO_EN selects fixed M1 priority.
module ram_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int WDT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        m_req_valid,
  output logic [1:0]        m_req_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_wen,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [WDT_W-1:0]  m0_wdt,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_wen,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [WDT_W-1:0]  m1_wdt,
  output logic [1:0]        m_resp_valid,
  output logic [DATA_W-1:0] m_resp_rdata,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [WDT_W-1:0]  wdt_op,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WDT_W-1:0]  wdt_q;
  logic [1:0]        grant;
  logic              handshake;

`ifdef RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = 2'b00;
    if (m_req_valid[1])      grant = 2'b10;
    else if (m_req_valid[0]) grant = 2'b01;
  end
`else
  logic rr_ptr_q;

  always_comb begin
    grant = 2'b00;
    case (m_req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end
`endif

  // Gated by rst_n so a reset cycle neither accepts a request nor emits a response.
  assign handshake = (state_q == IDLE) && rst_n && (grant != 2'b00);

  always_comb begin
    state_d      = state_q;
    m_req_ready  = 2'b00;
    m_resp_valid = 2'b00;
    m_resp_rdata = '0;
    mem_raddr    = '0;
    mem_waddr    = '0;
    mem_wdata    = '0;
    mem_ren      = 1'b0;
    mem_wen      = 1'b0;
    wdt_op       = '0;
    case (state_q)
      IDLE: begin
        m_req_ready = rst_n ? grant : 2'b00;
        if (grant != 2'b00) state_d = ISSUE;
      end
      ISSUE: begin
        mem_ren   = ~wen_q;
        mem_wen   = wen_q;
        mem_raddr = addr_q;
        mem_waddr = addr_q;
        mem_wdata = wdata_q;
        wdt_op    = wdt_q;
        state_d   = RESP;
      end
      RESP: begin
        // RAM output mux is combinational on address/width, so hold them here.
        mem_raddr    = addr_q;
        wdt_op       = wdt_q;
        m_resp_valid = rst_n ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        m_resp_rdata = (rst_n && !wen_q) ? mem_rdata : '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wdt_q   <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      rr_ptr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (handshake) begin
        owner_q <= grant[1];
        addr_q  <= grant[1] ? m1_addr  : m0_addr;
        wen_q   <= grant[1] ? m1_wen   : m0_wen;
        wdata_q <= grant[1] ? m1_wdata : m0_wdata;
        wdt_q   <= grant[1] ? m1_wdt   : m0_wdt;
`ifndef RAM_ARB_FIXED_PRIO_EN
        rr_ptr_q <= ~grant[1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter: byte-array RAM model plus a transaction-level reference (occupancy window, grant policy, reference memory).
module tb_ram_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int WW = 4;
  localparam logic [3:0] WDT8 = 4'd0, WDT16 = 4'd1, WDT32 = 4'd2, WDT64 = 4'd3;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [3:0]  wdt;
  } req_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    m_req_valid = 2'b00;
  logic [1:0]    m_req_ready;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic          m0_wen = 1'b0, m1_wen = 1'b0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic [WW-1:0] m0_wdt = '0, m1_wdt = '0;
  logic [1:0]    m_resp_valid;
  logic [DW-1:0] m_resp_rdata;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ren, mem_wen;
  logic [WW-1:0] wdt_op;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WDT_W(WW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wdt(m0_wdt),
    .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wdt(m1_wdt),
    .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .wdt_op(wdt_op), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [3:0] w);
    case (w)
      WDT8:    return 1;
      WDT16:   return 2;
      WDT32:   return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 7 + 3) ^ (i >> 3));
  endfunction

  // RAM model: strobes sampled at posedge, read data registered for one cycle.
  logic [7:0] ram [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = init_byte(i);
    forever begin
      @(posedge clk);
      if (mem_wen === 1'b1)
        for (int i = 0; i < nbytes(wdt_op); i++)
          ram[(int'(mem_waddr[11:0]) + i) % 4096] = mem_wdata[8*i +: 8];
      if (mem_ren === 1'b1) begin
        logic [63:0] rd;
        rd = '0;
        for (int i = 0; i < nbytes(wdt_op); i++)
          rd[8*i +: 8] = ram[(int'(mem_raddr[11:0]) + i) % 4096];
        mem_rdata = rd;
      end
    end
  end

  // Reference model: each accepted transaction owns cycles hs..hs+2.
  logic [7:0]  ref_mem [0:4095];
  int          cyc = 0;
  int          free_cyc = 0;
  bit          pref = 1'b0;
  bit          cur_vld = 1'b0;
  int          cur_hs = 0;
  bit          cur_owner = 1'b0;
  req_t        cur;
  logic [63:0] cur_rdata = '0;
  bit [1:0]    hs_seen = 2'b00;
  int          log_owner[$];
  int          log_cyc[$];
  logic [63:0] last_rd [2];
  int          resp_cnt [2];

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
    last_rd[0] = '0; last_rd[1] = '0;
    resp_cnt[0] = 0; resp_cnt[1] = 0;
    forever begin
      logic [1:0]  e_rv, eg;
      logic [63:0] e_rd, e_raddr, e_waddr, e_wdata;
      logic        e_ren, e_wen;
      logic [3:0]  e_wdt;
      @(negedge clk);
      cyc++;
      hs_seen = m_req_valid & m_req_ready;
      if (!rst_n) begin
        check("rst_ready", 64'(m_req_ready), 64'd0);
        check("rst_resp_valid", 64'(m_resp_valid), 64'd0);
        cur_vld  = 1'b0;
        free_cyc = cyc + 1;
        pref     = 1'b0;
      end else begin
        e_rv = 2'b00; e_rd = '0; e_raddr = '0; e_waddr = '0; e_wdata = '0;
        e_ren = 1'b0; e_wen = 1'b0; e_wdt = '0;
        if (cur_vld && cyc == cur_hs + 1) begin
          e_ren = !cur.wen; e_wen = cur.wen; e_raddr = cur.addr; e_waddr = cur.addr;
          e_wdata = cur.wdata; e_wdt = cur.wdt;
        end else if (cur_vld && cyc == cur_hs + 2) begin
          e_raddr = cur.addr; e_wdt = cur.wdt;
          e_rv = cur_owner ? 2'b10 : 2'b01;
          e_rd = cur.wen ? 64'd0 : cur_rdata;
        end
        check("resp_valid", 64'(m_resp_valid), 64'(e_rv));
        check("resp_rdata", m_resp_rdata, e_rd);
        check("mem_ren", 64'(mem_ren), 64'(e_ren));
        check("mem_wen", 64'(mem_wen), 64'(e_wen));
        check("mem_raddr", mem_raddr, e_raddr);
        check("mem_waddr", mem_waddr, e_waddr);
        check("mem_wdata", mem_wdata, e_wdata);
        check("wdt_op", 64'(wdt_op), 64'(e_wdt));
        if (m_resp_valid == 2'b01 || m_resp_valid == 2'b10) begin
          last_rd[m_resp_valid[1]] = m_resp_rdata;
          resp_cnt[m_resp_valid[1]]++;
        end
        if (e_rv != 2'b00) cur_vld = 1'b0;

        eg = 2'b00;
        if (cyc >= free_cyc) begin
          if (m_req_valid == 2'b11) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            eg = 2'b10;
`else
            eg = pref ? 2'b10 : 2'b01;
`endif
          end else eg = m_req_valid;
        end
        check("req_ready", 64'(m_req_ready), 64'(eg));
        if (eg != 2'b00) begin
          cur_owner = eg[1];
          cur.addr  = eg[1] ? m1_addr  : m0_addr;
          cur.wen   = eg[1] ? m1_wen   : m0_wen;
          cur.wdata = eg[1] ? m1_wdata : m0_wdata;
          cur.wdt   = eg[1] ? m1_wdt   : m0_wdt;
          cur_hs = cyc; cur_vld = 1'b1; free_cyc = cyc + 3; pref = !eg[1];
          cur_rdata = '0;
          for (int i = 0; i < nbytes(cur.wdt); i++) begin
            if (cur.wen) ref_mem[(int'(cur.addr[11:0]) + i) % 4096] = cur.wdata[8*i +: 8];
            else cur_rdata[8*i +: 8] = ref_mem[(int'(cur.addr[11:0]) + i) % 4096];
          end
          log_owner.push_back(int'(eg[1]));
          log_cyc.push_back(cyc);
        end
      end
    end
  end

  // Stimulus: per-master request queues; valid held until the handshake unless withdrawn.
  req_t q0[$], q1[$];
  int   drop_pct = 0;

  function automatic req_t mk(input logic [63:0] a, input logic w, input logic [63:0] d, input logic [3:0] t);
    req_t r;
    r.addr = a; r.wen = w; r.wdata = d; r.wdt = t;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (hs_seen[0] && q0.size() > 0) void'(q0.pop_front());
    if (hs_seen[1] && q1.size() > 0) void'(q1.pop_front());
    m_req_valid = 2'b00;
    m0_addr = {$urandom, $urandom}; m0_wdata = {$urandom, $urandom}; m0_wen = 1'($urandom); m0_wdt = 4'($urandom);
    m1_addr = {$urandom, $urandom}; m1_wdata = {$urandom, $urandom}; m1_wen = 1'($urandom); m1_wdt = 4'($urandom);
    if (q0.size() > 0 && int'($urandom_range(0, 99)) >= drop_pct) begin
      m_req_valid[0] = 1'b1;
      m0_addr = q0[0].addr; m0_wen = q0[0].wen; m0_wdata = q0[0].wdata; m0_wdt = q0[0].wdt;
    end
    if (q1.size() > 0 && int'($urandom_range(0, 99)) >= drop_pct) begin
      m_req_valid[1] = 1'b1;
      m1_addr = q1[0].addr; m1_wen = q1[0].wen; m1_wdata = q1[0].wdata; m1_wdt = q1[0].wdt;
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0) && k < budget) begin
      step();
      k++;
    end
    check("drain_in_budget", 64'(k < budget), 64'd1);
    q0.delete(); q1.delete();
    repeat (4) step();
  endtask

  function automatic req_t rnd_req();
    logic [3:0] t;
    t = 4'($urandom_range(0, 3));
    return mk(64'h8000_0000 + 64'($urandom_range(0, 4088)), 1'($urandom), {$urandom, $urandom}, t);
  endfunction

  initial begin
    int base;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("reset_ready", 64'(m_req_ready), 64'd0);
    check("reset_resp", 64'(m_resp_valid), 64'd0);
    check("reset_strobes", 64'({mem_ren, mem_wen}), 64'd0);

    // M0 read alone, then M1 write/read of a 64-bit word
    q0.push_back(mk(64'h8000_0000, 1'b0, 64'd0, WDT32));
    drain(50);
    check("t1_rd_resp_count", 64'(resp_cnt[0]), 64'd1);
    q1.push_back(mk(64'h8000_0010, 1'b1, 64'h1122334455667788, WDT64));
    q1.push_back(mk(64'h8000_0010, 1'b0, 64'd0, WDT64));
    drain(50);
    check("t2_read_back", last_rd[1], 64'h1122334455667788);

    // Both masters saturating: arbitration order and 3-cycle spacing
    log_owner.delete(); log_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      q0.push_back(rnd_req());
      q1.push_back(rnd_req());
    end
    step();
    repeat (18) step();
    check("t3_grant_count", 64'(log_owner.size() >= 6), 64'd1);
    for (int i = 0; i < 6 && i < log_owner.size(); i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      check("t4_fixed_owner", 64'(log_owner[i]), 64'd1);
`else
      check("t3_rr_owner", 64'(log_owner[i]), 64'(i % 2));
`endif
      if (i > 0) check("t3_spacing", 64'(log_cyc[i] - log_cyc[i-1]), 64'd3);
    end
    drain(200);

    // Byte store then byte load
    q0.push_back(mk(64'h8000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFAB, WDT8));
    q0.push_back(mk(64'h8000_0003, 1'b0, 64'd0, WDT8));
    drain(50);
    check("t5_byte_read", last_rd[0], 64'h0000_0000_0000_00AB);

    // Reset during the response cycle of an M1 read
    base = resp_cnt[1];
    q1.push_back(mk(64'h8000_0020, 1'b0, 64'd0, WDT64));
    for (int k = 0; k < 20 && q1.size() > 0; k++) step();
    check("t6_handshake_seen", 64'(q1.size()), 64'd0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (2) step();
    check("t6_no_resp", 64'(resp_cnt[1]), 64'(base));
    log_owner.delete(); log_cyc.delete();
    q0.push_back(rnd_req());
    q1.push_back(rnd_req());
    drain(50);
    check("t6_grants", 64'(log_owner.size()), 64'd2);
`ifdef RAM_ARB_FIXED_PRIO_EN
    if (log_owner.size() > 0) check("t6_first_owner", 64'(log_owner[0]), 64'd1);
`else
    if (log_owner.size() > 0) check("t6_first_owner", 64'(log_owner[0]), 64'd0);
`endif

    // Random traffic with withdrawn valids
    drop_pct = 25;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 0) q0.push_back(rnd_req());
      else q1.push_back(rnd_req());
    end
    drain(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
